// File: rtl/stopwatch_bcd_if.sv
// rtl/stopwatch_bcd_if.sv - control pulses and display outputs of stopwatch_bcd
interface stopwatch_bcd_if;
    logic        start_stop;
    logic        zero;
    logic        lap;
    logic [15:0] x;
    logic        running;
    logic        overflow;

    modport master (
        output start_stop, zero, lap,
        input  x, running, overflow
    );

    modport slave (
        input  start_stop, zero, lap,
        output x, running, overflow
    );
endinterface

// File: rtl/stopwatch_bcd.sv
// rtl/stopwatch_bcd.sv - centisecond BCD stopwatch (SS.CC) for a 4-digit display
// Optional lap freeze of the displayed value is built when LAP_EN is defined.
module stopwatch_bcd #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int TICK_DIV = CLK_HZ / 100
) (
    input  logic            clk,
    input  logic            clr_n,
    stopwatch_bcd_if.slave  bus
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, OVF} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] presc;
    logic [15:0]   digits;
    logic [15:0]   digits_inc;
    logic [15:0]   x_src;
    logic [15:0]   x_q;
    logic          running_q, overflow_q;
    logic          running_nxt, overflow_nxt;
    logic          tick;
    logic          all_nine;
    logic          carry;

    assign tick     = (state == RUN) && (presc == PRESC_LAST);
    assign all_nine = (digits == 16'h9999);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start_stop) state_nxt = RUN;
            RUN: begin
                if (tick && all_nine)     state_nxt = OVF;
                else if (bus.start_stop)  state_nxt = PAUSE;
            end
            PAUSE: begin
                if (bus.zero)             state_nxt = IDLE;
                else if (bus.start_stop)  state_nxt = RUN;
            end
            OVF:     if (bus.zero) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        running_nxt  = (state_nxt == RUN);
        overflow_nxt = (state_nxt == OVF);
    end

    // Ripple the +1 through the four decades; a 9 wraps to 0 and passes the carry on.
    always_comb begin
        digits_inc = digits;
        carry      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (digits[i*4 +: 4] == 4'd9) begin
                    digits_inc[i*4 +: 4] = 4'd0;
                end else begin
                    digits_inc[i*4 +: 4] = digits[i*4 +: 4] + 4'd1;
                    carry                = 1'b0;
                end
            end
        end
    end

`ifdef LAP_EN
    logic        frozen;
    logic [15:0] snap;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            frozen <= 1'b0;
            snap   <= 16'h0000;
        end else if (state_nxt == IDLE || state_nxt == OVF) begin
            frozen <= 1'b0;
        end else if (state == RUN && bus.lap) begin
            frozen <= !frozen;
            if (!frozen) snap <= digits;
        end
    end

    assign x_src = frozen ? snap : digits;
`else
    logic lap_unused;
    assign lap_unused = bus.lap;
    assign x_src      = digits;
`endif

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state      <= IDLE;
            presc      <= '0;
            digits     <= 16'h0000;
            x_q        <= 16'h0000;
            running_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            running_q  <= running_nxt;
            overflow_q <= overflow_nxt;
            x_q        <= (state == OVF) ? 16'hAAAA : x_src;

            if (state_nxt == IDLE)  presc <= '0;
            else if (tick)          presc <= '0;
            else if (state == RUN)  presc <= presc + 1'b1;

            // The tick that lands on 99.99 moves to OVF and leaves the digits pinned.
            if (state_nxt == IDLE)         digits <= 16'h0000;
            else if (tick && !all_nine)    digits <= digits_inc;
        end
    end

    assign bus.x        = x_q;
    assign bus.running  = running_q;
    assign bus.overflow = overflow_q;
endmodule
